mux_arbiter_2: RTL and testbench

Packet-level round-robin arbiter directly upstream of the 2:1 router output mux; drives the mux one-hot `sel` bus.
- Watches the valid flag and flit-type field of both mux inputs.
- Locks the winning input from HEAD flit to TAIL flit, so packets never interleave on the output port.
- Returns per-input grants to the senders, which hold flits until granted.

---
 rtl/mux_arbiter_2_pkg.sv | 21 ++
 rtl/mux_arbiter_2_rr_pick_2.sv | 14 +
 rtl/mux_arbiter_2.sv | 127 ++++++++++++
 tb/tb_mux_arbiter_2.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter_2_pkg.sv
// Shared constants and encodings for the 2-input packet arbiter and its helpers.
package mux_arbiter_2_pkg;

  localparam int unsigned TYPEW  = 2;
  localparam int unsigned NPORTS = 2;
  localparam int unsigned SELW   = 5;

  typedef enum logic [TYPEW-1:0] {
    TYPE_NONE = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_TAIL = 2'b10,
    TYPE_DATA = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

endpackage

// File: rtl/mux_arbiter_2_rr_pick_2.sv
// Combinational two-way round-robin pick: rr_i selects which requester wins a tie.
module rr_pick_2 (
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o    = '0;
    win_o[0] = req_i[0] & (~req_i[1] | ~rr_i);
    win_o[1] = req_i[1] & (~req_i[0] |  rr_i);
  end

endmodule

// File: rtl/mux_arbiter_2.sv
// Packet-level round-robin arbiter driving the one-hot select of a 2:1 output mux.
// Optional MUX_ARBITER_FASTSWITCH_EN: tail on one input hands over directly to a pending head.
module mux_arbiter_2 #(
  parameter int unsigned TYPEW = 2,
  parameter int unsigned SELW  = 5
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  input  logic             ordy,
  output logic [SELW-1:0]  sel,
  output logic             ogrant_0,
  output logic             ogrant_1,
  output logic             obusy,
  output logic             oerr
);

  import mux_arbiter_2_pkg::*;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              hd_q, hd_d;
  logic              err_q, err_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              g0_q, g0_d;
  logic              g1_q, g1_d;
  logic              busy_q, busy_d;

  logic [1:0]        req;
  logic [1:0]        win;
  logic              lk;
  logic              xfer;
  logic [TYPEW-1:0]  t;

  assign req[0] = ivalid_0 & (itype_0 == TYPE_HEAD);
  assign req[1] = ivalid_1 & (itype_1 == TYPE_HEAD);

  rr_pick_2 u_pick (
    .req_i (req),
    .rr_i  (rr_q),
    .win_o (win)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      hd_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hd_q    <= hd_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      busy_q  <= busy_d;
    end
  end

  // The held head flit crosses on the first granted cycle; only a second HEAD in the lock is an error.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hd_d    = hd_q;
    err_d   = 1'b0;
    lk      = (state_q == LOCK1);
    xfer    = (lk ? ivalid_1 : ivalid_0) & ordy;
    t       = lk ? itype_1 : itype_0;
    case (state_q)
      IDLE: begin
        hd_d  = 1'b0;
        err_d = (ivalid_0 & ((itype_0 == TYPE_DATA) | (itype_0 == TYPE_TAIL))) |
                (ivalid_1 & ((itype_1 == TYPE_DATA) | (itype_1 == TYPE_TAIL)));
        if (win[0]) begin
          state_d = LOCK0;
          rr_d    = 1'b1;
        end else if (win[1]) begin
          state_d = LOCK1;
          rr_d    = 1'b0;
        end
      end
      LOCK0, LOCK1: begin
        if (xfer) begin
          if (t == TYPE_HEAD) begin
            if (hd_q) err_d = 1'b1;
            else      hd_d  = 1'b1;
          end else if (t == TYPE_TAIL) begin
            hd_d    = 1'b0;
            state_d = IDLE;
`ifdef MUX_ARBITER_FASTSWITCH_EN
            if (lk ? req[0] : req[1]) begin
              state_d = lk ? LOCK0 : LOCK1;
              rr_d    = lk;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    g0_d     = (state_d == LOCK0);
    g1_d     = (state_d == LOCK1);
    busy_d   = (state_d != IDLE);
    sel_d    = '0;
    sel_d[0] = g0_d;
    sel_d[1] = g1_d;
  end

  assign sel      = sel_q;
  assign ogrant_0 = g0_q;
  assign ogrant_1 = g1_q;
  assign obusy    = busy_q;
  assign oerr     = err_q;

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Self-checking bench for mux_arbiter_2: packet-level reference model plus directed scenarios.
module tb_mux_arbiter_2;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       ivalid_0 = 1'b0;
  logic       ivalid_1 = 1'b0;
  logic [1:0] itype_0 = 2'b00;
  logic [1:0] itype_1 = 2'b00;
  logic       ordy = 1'b1;
  logic [4:0] sel;
  logic       ogrant_0, ogrant_1, obusy, oerr;

  int passes = 0;
  int total  = 0;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_DATA = 2'b11;

  always #5 clk = ~clk;

  mux_arbiter_2 #(.TYPEW(2), .SELW(5)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .ivalid_0 (ivalid_0),
    .itype_0  (itype_0),
    .ivalid_1 (ivalid_1),
    .itype_1  (itype_1),
    .ordy     (ordy),
    .sel      (sel),
    .ogrant_0 (ogrant_0),
    .ogrant_1 (ogrant_1),
    .obusy    (obusy),
    .oerr     (oerr)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: which input owns the port, whose turn it is, whether the head has crossed.
  typedef struct packed {
    int owner;
    int rr;
    bit hd;
    bit err;
  } mstate_t;

  mstate_t ms = '{-1, 0, 1'b0, 1'b0};

  function automatic mstate_t model_next(mstate_t s, bit v0, bit [1:0] t0,
                                         bit v1, bit [1:0] t1, bit rdy);
    mstate_t n = s;
    bit h0, h1, v;
    bit [1:0] t;
    int o;
    n.err = 1'b0;
    h0 = v0 && (t0 == T_HEAD);
    h1 = v1 && (t1 == T_HEAD);
    if (s.owner < 0) begin
      if (v0 && (t0 == T_DATA || t0 == T_TAIL)) n.err = 1'b1;
      if (v1 && (t1 == T_DATA || t1 == T_TAIL)) n.err = 1'b1;
      if (h0 && h1) n.owner = s.rr;
      else if (h0)  n.owner = 0;
      else if (h1)  n.owner = 1;
      if (n.owner >= 0) begin
        n.rr = 1 - n.owner;
        n.hd = 1'b0;
      end
    end else begin
      o = s.owner;
      v = (o == 1) ? v1 : v0;
      t = (o == 1) ? t1 : t0;
      if (v && rdy) begin
        if (t == T_HEAD) begin
          if (s.hd) n.err = 1'b1;
          else      n.hd  = 1'b1;
        end else if (t == T_TAIL) begin
          n.owner = -1;
          n.hd    = 1'b0;
`ifdef MUX_ARBITER_FASTSWITCH_EN
          if ((o == 0) ? h1 : h0) begin
            n.owner = 1 - o;
            n.rr    = o;
          end
`endif
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) ms <= '{-1, 0, 1'b0, 1'b0};
    else       ms <= model_next(ms, ivalid_0, itype_0, ivalid_1, itype_1, ordy);
  end

  always @(negedge clk) begin
    int es;
    es = (ms.owner == 0) ? 1 : (ms.owner == 1) ? 2 : 0;
    chk("model_sel",   int'(sel),      es);
    chk("model_g0",    int'(ogrant_0), int'(ms.owner == 0));
    chk("model_g1",    int'(ogrant_1), int'(ms.owner == 1));
    chk("model_busy",  int'(obusy),    int'(ms.owner >= 0));
    chk("model_err",   int'(oerr),     int'(ms.err));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    ivalid_0 = 1'b0;
    ivalid_1 = 1'b0;
    ordy     = 1'b1;
    rst_     = 1'b0;
    #2;
    rst_     = 1'b1;
    cyc();
  endtask

  initial begin
    int cnt, tails, c0, c1, bad, ph0, ph1;
    bit x0, x1;
    int order[$];

    // Reset held with both heads presented
    #1 rst_ = 1'b0;
    ivalid_0 = 1'b1; itype_0 = T_HEAD;
    ivalid_1 = 1'b1; itype_1 = T_HEAD;
    repeat (3) cyc();
    chk("rst_sel",  int'(sel), 0);
    chk("rst_g0",   int'(ogrant_0), 0);
    chk("rst_g1",   int'(ogrant_1), 0);
    chk("rst_busy", int'(obusy), 0);
    chk("rst_err",  int'(oerr), 0);

    // Release with only input 1 heading, then a 22-flit packet
    ivalid_0 = 1'b0;
    rst_     = 1'b1;
    cyc();
    chk("head_lat_sel", int'(sel), 2);
    chk("head_lat_g1",  int'(ogrant_1), 1);
    cnt = (sel == 5'b00010) ? 1 : 0;
    cyc();
    if (sel == 5'b00010) cnt++;
    itype_1 = T_DATA;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (sel == 5'b00010) cnt++;
    end
    itype_1 = T_TAIL;
    cyc();
    ivalid_1 = 1'b0;
    chk("hold_cycles",  cnt, 22);
    chk("tail_release", int'(sel), 0);
    chk("tail_busy",    int'(obusy), 0);

    // Simultaneous heads after reset
    do_reset();
    ivalid_0 = 1'b1; itype_0 = T_HEAD;
    ivalid_1 = 1'b1; itype_1 = T_HEAD;
    cyc();
    chk("sim_first", int'(sel), 1);
    cyc();
    itype_0 = T_DATA;
    cyc();
    itype_0 = T_TAIL;
    cyc();
    ivalid_0 = 1'b0;
`ifdef MUX_ARBITER_FASTSWITCH_EN
    chk("sim_switch", int'(sel), 2);
    chk("sim_busy",   int'(obusy), 1);
`else
    chk("sim_bubble", int'(sel), 0);
    cyc();
    chk("sim_second", int'(sel), 2);
`endif
    cyc();
    itype_1 = T_TAIL;
    cyc();
    ivalid_1 = 1'b0;
    chk("sim_done", int'(sel), 0);

    // Fairness: both senders keep offering HEAD/DATA/TAIL packets
    do_reset();
    tails = 0; ph0 = 0; ph1 = 0;
    for (int c = 0; c < 300 && tails < 10; c++) begin
      ivalid_0 = 1'b1;
      ivalid_1 = 1'b1;
      itype_0 = (ph0 == 0) ? T_HEAD : (ph0 == 1) ? T_DATA : T_TAIL;
      itype_1 = (ph1 == 0) ? T_HEAD : (ph1 == 1) ? T_DATA : T_TAIL;
      x0 = ogrant_0 && ordy;
      x1 = ogrant_1 && ordy;
      cyc();
      if (x0) begin
        if (ph0 == 2) begin tails++; order.push_back(0); end
        ph0 = (ph0 + 1) % 3;
      end
      if (x1) begin
        if (ph1 == 2) begin tails++; order.push_back(1); end
        ph1 = (ph1 + 1) % 3;
      end
    end
    ivalid_0 = 1'b0;
    ivalid_1 = 1'b0;
    c0 = 0; c1 = 0; bad = 0;
    foreach (order[k]) begin
      if (order[k] == 0) c0++; else c1++;
      if (order[k] != (k % 2)) bad++;
    end
    chk("fair_tails", tails, 10);
    chk("fair_in0",   c0, 5);
    chk("fair_in1",   c1, 5);
    chk("fair_alt",   bad, 0);

    // Stall: ordy low for 7 cycles, valid gaps for 3 of them
    do_reset();
    ivalid_0 = 1'b1; itype_0 = T_HEAD;
    cyc();
    chk("stall_grant", int'(sel), 1);
    cyc();
    itype_0 = T_DATA;
    cyc();
    ordy = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ivalid_0 = !(k >= 2 && k < 5);
      cyc();
      chk("stall_sel", int'(sel), 1);
      chk("stall_err", int'(oerr), 0);
    end
    ordy = 1'b1; ivalid_0 = 1'b1; itype_0 = T_DATA;
    cyc();
    chk("stall_resume", int'(sel), 1);
    itype_0 = T_TAIL;
    cyc();
    ivalid_0 = 1'b0;
    chk("stall_done", int'(sel), 0);

    // Protocol errors
    do_reset();
    ivalid_0 = 1'b1; itype_0 = T_DATA;
    cyc();
    chk("idle_data_err",  int'(oerr), 1);
    chk("idle_data_nogr", int'(sel), 0);
    itype_0 = T_NONE;
    cyc();
    chk("err_pulse_end",  int'(oerr), 0);
    chk("none_ignored",   int'(sel), 0);
    ivalid_0 = 1'b0;
    ivalid_1 = 1'b1; itype_1 = T_TAIL;
    cyc();
    chk("idle_tail_err",  int'(oerr), 1);
    ivalid_1 = 1'b0;
    ivalid_0 = 1'b1; itype_0 = T_HEAD;
    cyc();
    chk("err_lock_grant", int'(sel), 1);
    cyc();
    chk("first_head_ok",  int'(oerr), 0);
    itype_0 = T_DATA;
    cyc();
    itype_0 = T_HEAD;
    cyc();
    chk("lock_head_err",  int'(oerr), 1);
    chk("lock_held",      int'(sel), 1);
    itype_0 = T_DATA;
    cyc();
    chk("lock_err_end",   int'(oerr), 0);
    chk("lock_still",     int'(sel), 1);
    itype_0 = T_TAIL;
    cyc();
    ivalid_0 = 1'b0;
    chk("err_pkt_done",   int'(sel), 0);
    cyc();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
